// File: rtl/hex_scroll_ctrl_pkg.sv
// Shared types and defaults for the hex display scroll controller and its prescaler.
// Holds the controller state encoding and the default geometry and timing.
package hex_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    SHOW   = 2'd2
  } state_t;

  localparam int DIGITS_DEF   = 6;
  localparam int TICK_DIV_DEF = 25_000_000;

  localparam logic [DIGITS_DEF-1:0] OFF_ALL = '1;

endpackage

// File: rtl/hex_scroll_ctrl_tick_gen.sv
// Prescaler: counts 0..DIV-1 and pulses tick for the single cycle the count sits at DIV-1.
// A synchronous clear holds the count at zero while no scroll is in progress.
module tick_gen
  import hex_disp_pkg::*;
#(
  parameter int DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Six-digit hex display sequencer: accepts a value over valid/ready, scrolls it in from
// the right one digit per prescaler tick, then holds it with optional leading-zero blanking.
module hex_scroll_ctrl
  import hex_disp_pkg::*;
#(
  parameter int DIGITS   = DIGITS_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  scroll_en,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   digit_val,
  output logic [DIGITS-1:0]     digit_off,
  output logic                  busy
);

  localparam int VW    = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS + 1);
  localparam logic [DIGITS-1:0] OFF_ONES = '1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  state_t            state;
  logic [VW-1:0]     src;
  logic [IDX_W-1:0]  idx;
  logic              tick;
  logic              accept;
  logic              zero_above;
  logic [DIGITS-1:0] lz_mask;

  assign load_ready = (state != SCROLL);
  assign busy       = (state == SCROLL);
  assign accept     = load_valid && load_ready;

  // The prescaler only runs while scrolling, so every scroll starts from a zero count.
  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != SCROLL),
    .tick (tick)
  );

  // Digit i goes dark only when it and every digit to its left are zero; digit 0 always shows.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (src[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_above;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src       <= '0;
      idx       <= '0;
      digit_val <= '0;
      digit_off <= OFF_ONES;
    end else if (accept) begin
      src <= load_data;
      idx <= '0;
      if (scroll_en) begin
        state     <= SCROLL;
        digit_val <= '0;
        digit_off <= OFF_ONES;
      end else begin
        state     <= SHOW;
        digit_val <= load_data;
        digit_off <= '0;
      end
    end else begin
      case (state)
        SCROLL: begin
          if (tick) begin
            // Most significant source digit enters first and walks left on later ticks.
            digit_val <= {digit_val[VW-5:0], src[4*(DIGITS-1-int'(idx)) +: 4]};
            digit_off <= {digit_off[DIGITS-2:0], 1'b0};
            idx       <= idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
              state <= SHOW;
            end
          end
        end
        SHOW: begin
          digit_val <= src;
          digit_off <= blank_lz ? lz_mask : '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
